// File: rtl/dip_scan_reader.sv
// dip_scan_reader: drives a 74HC165-style DIP chain and produces a debounced,
// optionally byte-swapped switch word with a change pulse.
module dip_scan_reader #(
  parameter int WIDTH         = 16,
  parameter int CLK_DIV       = 2,
  parameter int BYTE_SWAP     = 1,
  parameter int STABLE_FRAMES = 2,
  parameter int AUTO_SCAN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DIP_in,
  input  logic             scan_req,
  output logic             DIP_latch,
  output logic             DIP_sclk,
  output logic [WIDTH-1:0] DIP_data,
  output logic             DIP_valid,
  output logic             DIP_changed,
  output logic             busy
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(WIDTH);
  localparam int MW = $clog2(STABLE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, UPDATE} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_div;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_shift, r_cand, w_frame;
  logic [MW-1:0]    r_match, w_match;

  generate
    if (BYTE_SWAP != 0) begin : g_swap
      for (genvar k = 0; k < WIDTH / 8; k++) begin : g_byte
        assign w_frame[8*k +: 8] = r_shift[WIDTH-8*(k+1) +: 8];
      end
    end else begin : g_plain
      assign w_frame = r_shift;
    end
  endgenerate

  // Saturating run length of identical frames, restarting at 1 on any difference.
  assign w_match = (w_frame != r_cand) ? MW'(1) :
                   (r_match == MW'(STABLE_FRAMES)) ? r_match : r_match + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_cand      <= '0;
      r_match     <= '0;
      DIP_latch   <= 1'b1;
      DIP_sclk    <= 1'b0;
      DIP_data    <= '0;
      DIP_valid   <= 1'b0;
      DIP_changed <= 1'b0;
      busy        <= 1'b0;
    end else begin
      DIP_changed <= 1'b0;
      case (r_state)
        IDLE: if (AUTO_SCAN != 0 || scan_req) begin
          r_state   <= LATCH;
          DIP_latch <= 1'b0;
          busy      <= 1'b1;
          r_div     <= '0;
        end
        LATCH: if (r_div == DW'(CLK_DIV - 1)) begin
          r_state   <= SHIFT;
          DIP_latch <= 1'b1;
          r_div     <= '0;
        end else r_div <= r_div + 1'b1;
        SHIFT: begin
          // Sample on the edge that raises sclk: the chain output is settled by then.
          if (r_div == DW'(CLK_DIV - 1)) begin
            r_shift  <= {r_shift[WIDTH-2:0], DIP_in};
            DIP_sclk <= 1'b1;
          end
          if (r_div == DW'(2 * CLK_DIV - 1)) begin
            DIP_sclk <= 1'b0;
            r_div    <= '0;
            r_bit    <= (r_bit == BW'(WIDTH - 1)) ? '0 : r_bit + 1'b1;
            if (r_bit == BW'(WIDTH - 1)) r_state <= UPDATE;
          end else r_div <= r_div + 1'b1;
        end
        UPDATE: begin
          r_cand  <= w_frame;
          r_match <= w_match;
          if (w_match >= MW'(STABLE_FRAMES) && (!DIP_valid || w_frame != DIP_data)) begin
            DIP_data    <= w_frame;
            DIP_valid   <= 1'b1;
            DIP_changed <= 1'b1;
          end
          if (AUTO_SCAN != 0) begin
            r_state   <= LATCH;
            DIP_latch <= 1'b0;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dip_scan_reader.sv
// tb_dip_scan_reader: three reader configurations, each fed by a behavioural 74HC165 chain.
module tb_dip_scan_reader;
  logic clk = 1'b0, rst = 1'b1, scan_req = 1'b0;
  always #5 clk = ~clk;

  logic        latch_a, sclk_a, valid_a, ch_a, busy_a;
  logic [15:0] data_a, w_a = '0, sh_a;
  logic        latch_b, sclk_b, valid_b, ch_b, busy_b;
  logic [15:0] data_b, w_b = '0, sh_b;
  logic        latch_c, sclk_c, valid_c, ch_c, busy_c;
  logic [23:0] data_c, w_c = '0, sh_c;

  // Chain model: parallel load while latch is low, shift toward Q7 on each sclk rise.
  always @(posedge sclk_a or negedge latch_a) sh_a <= !latch_a ? w_a : {sh_a[14:0], 1'b0};
  always @(posedge sclk_b or negedge latch_b) sh_b <= !latch_b ? w_b : {sh_b[14:0], 1'b0};
  always @(posedge sclk_c or negedge latch_c) sh_c <= !latch_c ? w_c : {sh_c[22:0], 1'b0};

  dip_scan_reader u_a (
    .clk(clk), .rst(rst), .DIP_in(sh_a[15]), .scan_req(scan_req),
    .DIP_latch(latch_a), .DIP_sclk(sclk_a), .DIP_data(data_a),
    .DIP_valid(valid_a), .DIP_changed(ch_a), .busy(busy_a));

  dip_scan_reader #(.AUTO_SCAN(0)) u_b (
    .clk(clk), .rst(rst), .DIP_in(sh_b[15]), .scan_req(scan_req),
    .DIP_latch(latch_b), .DIP_sclk(sclk_b), .DIP_data(data_b),
    .DIP_valid(valid_b), .DIP_changed(ch_b), .busy(busy_b));

  dip_scan_reader #(.WIDTH(24), .BYTE_SWAP(0), .STABLE_FRAMES(1)) u_c (
    .clk(clk), .rst(rst), .DIP_in(sh_c[23]), .scan_req(scan_req),
    .DIP_latch(latch_c), .DIP_sclk(sclk_c), .DIP_data(data_c),
    .DIP_valid(valid_c), .DIP_changed(ch_c), .busy(busy_c));

  typedef struct {
    logic [15:0] word;
    logic [15:0] data;
    logic        valid;
    logic        changed;
  } vec_t;

  vec_t vecs[18];
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_fall_a();
    bit   ok = 1'b0;
    logic prev = latch_a;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (prev && !latch_a) ok = 1'b1;
      prev = latch_a;
    end
    chk("latch_fall_timeout", {31'b0, ok}, 32'd1);
  endtask

  // Frame lo must already be loaded into w_a; each later frame start marks the
  // point where the previous frame's result has just been registered.
  task automatic run_vecs(input int lo, input int hi);
    wait_fall_a();
    for (int i = lo; i <= hi; i++) begin
      w_a = (i < hi) ? vecs[i+1].word : vecs[i].word;
      wait_fall_a();
      chk($sformatf("vec%0d_data", i), {16'b0, data_a}, {16'b0, vecs[i].data});
      chk($sformatf("vec%0d_valid", i), {31'b0, valid_a}, {31'b0, vecs[i].valid});
      chk($sformatf("vec%0d_changed", i), {31'b0, ch_a}, {31'b0, vecs[i].changed});
    end
  endtask

  task automatic set(input int i, input logic [15:0] w, input logic [15:0] d, input logic v, input logic c);
    vecs[i].word = w; vecs[i].data = d; vecs[i].valid = v; vecs[i].changed = c;
  endtask

  int   lat_lo, sclk_hi, rises, bad_per, last_rise, bsy, falls, chg;
  logic psclk, prev;

  initial begin
    set(0, 16'h12AB, 16'h0000, 0, 0);
    set(1, 16'h12AB, 16'hAB12, 1, 1);
    set(2, 16'h00FF, 16'hAB12, 1, 0);
    set(3, 16'h00FE, 16'hAB12, 1, 0);
    set(4, 16'h00FF, 16'hAB12, 1, 0);
    set(5, 16'h00FF, 16'hFF00, 1, 1);
    set(6, 16'h5555, 16'hFF00, 1, 0);
    set(7, 16'h5555, 16'h5555, 1, 1);
    for (int i = 8; i < 16; i++) set(i, 16'h5555, 16'h5555, 1, 0);
    set(16, 16'h0000, 16'h0000, 0, 0);
    set(17, 16'h0000, 16'h0000, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_latch", {31'b0, latch_a}, 32'd1);
    chk("rst_sclk", {31'b0, sclk_a}, 32'd0);
    chk("rst_data", {16'b0, data_a}, 32'd0);
    chk("rst_valid", {31'b0, valid_a}, 32'd0);
    chk("rst_changed", {31'b0, ch_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);

    // Frame timing at defaults: 2-cycle latch, 16 sclk pulses of period 4, 67-cycle frame.
    w_a = 16'h12AB;
    lat_lo = 0; sclk_hi = 0; rises = 0; bad_per = 0; last_rise = -1; bsy = 0; psclk = 1'b0;
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 136; k++) begin
      @(posedge clk);
      #1;
      if (k <= 67) begin
        if (!latch_a) lat_lo++;
        if (sclk_a) sclk_hi++;
        if (busy_a) bsy++;
        if (sclk_a && !psclk) begin
          rises++;
          if (last_rise >= 0 && k - last_rise != 4) bad_per++;
          last_rise = k;
        end
      end
      psclk = sclk_a;
      if (k == 67) chk("latch_high_in_update", {31'b0, latch_a}, 32'd1);
      if (k == 68) chk("latch_low_next_frame", {31'b0, latch_a}, 32'd0);
      if (k == 68) chk("valid_after_frame1", {31'b0, valid_a}, 32'd0);
      if (k == 134) chk("valid_before_frame2", {31'b0, valid_a}, 32'd0);
      if (k == 135) begin
        chk("frame2_data", {16'b0, data_a}, 32'h0000AB12);
        chk("frame2_valid", {31'b0, valid_a}, 32'd1);
        chk("frame2_changed", {31'b0, ch_a}, 32'd1);
      end
      if (k == 136) chk("changed_one_cycle", {31'b0, ch_a}, 32'd0);
    end
    chk("latch_low_cycles", lat_lo, 2);
    chk("sclk_high_cycles", sclk_hi, 32);
    chk("sclk_rises", rises, 16);
    chk("sclk_period_errors", bad_per, 0);
    chk("busy_cycles_auto", bsy, 67);

    // Table run: acceptance, bounce, and a long stable stretch.
    rst = 1'b1;
    w_a = vecs[0].word;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_vecs(0, 15);

    // Reset during the high phase of bit 7.
    repeat (32) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'b0, busy_a}, 32'd1);
    chk("pre_rst_sclk", {31'b0, sclk_a}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_latch", {31'b0, latch_a}, 32'd1);
    chk("midrst_sclk", {31'b0, sclk_a}, 32'd0);
    chk("midrst_data", {16'b0, data_a}, 32'd0);
    chk("midrst_valid", {31'b0, valid_a}, 32'd0);
    chk("midrst_changed", {31'b0, ch_a}, 32'd0);
    chk("midrst_busy", {31'b0, busy_a}, 32'd0);
    w_a = vecs[16].word;
    @(negedge clk) rst = 1'b0;
    run_vecs(16, 17);

    // 24-bit, no swap, single-frame acceptance: frame = 2 + 2*2*24 + 1 = 99 cycles.
    rst = 1'b1;
    w_c = 24'hC0FFEE;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      @(posedge clk);
      #1;
      if (k == 99) chk("w24_data_before", {8'b0, data_c}, 32'd0);
      if (k == 100) begin
        chk("w24_data", {8'b0, data_c}, 32'h00C0FFEE);
        chk("w24_valid", {31'b0, valid_c}, 32'd1);
        chk("w24_changed", {31'b0, ch_c}, 32'd1);
      end
      if (k == 101) chk("w24_changed_clear", {31'b0, ch_c}, 32'd0);
    end

    // On-request mode: one frame per request, a mid-frame request is dropped.
    rst = 1'b1;
    w_b = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("req_idle_busy", {31'b0, busy_b}, 32'd0);
    chk("req_idle_latch", {31'b0, latch_b}, 32'd1);
    scan_req = 1'b1;
    bsy = 0; falls = 0; prev = latch_b;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk);
      #1;
      if (busy_b) bsy++;
      if (prev && !latch_b) falls++;
      prev = latch_b;
      scan_req = (c == 30);
    end
    chk("req_busy_cycles", bsy, 67);
    chk("req_frame_count", falls, 1);
    chk("req_end_latch", {31'b0, latch_b}, 32'd1);
    chk("req_end_busy", {31'b0, busy_b}, 32'd0);
    chk("req_one_frame_valid", {31'b0, valid_b}, 32'd0);
    scan_req = 1'b1;
    chg = 0;
    for (int c = 0; c < 75; c++) begin
      @(posedge clk);
      #1;
      scan_req = 1'b0;
      if (ch_b) chg++;
    end
    chk("req2_data", {16'b0, data_b}, 32'h00003412);
    chk("req2_valid", {31'b0, valid_b}, 32'd1);
    chk("req2_changed_pulses", chg, 1);
    chk("req2_idle", {31'b0, busy_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
